// File: rtl/uart_alu_ctrl.sv
`timescale 1ns/1ps
// Command packet engine behind the UART byte streams: parses opcode/len headers,
// echoes payloads or reduces 32-bit little-endian words (ADD/XOR), and answers on TX.
module uart_alu_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    output logic [DATA_WIDTH-1:0] tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_XOR  = 8'hA1;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        S_HDR,
        S_ECHO,
        S_OPND,
        S_RESP,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  hdr_cnt;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic [15:0] rem;
    logic [31:0] acc;
    logic [31:0] word;
    logic [1:0]  wcnt;
    logic [2:0]  out_cnt;

    logic [15:0] len_full;
    logic [15:0] rem_hdr;
    logic [31:0] word_full;
    logic        tx_free;
    logic        tx_load;
    logic [7:0]  tx_load_data;
    logic        rx_fire;

    // Handshake: a beat moves on a rising edge when valid && ready; the TX register
    // is a single-entry buffer that may be refilled in the same cycle it drains.
    assign tx_free   = !tx_tvalid || tx_tready;
    assign len_full  = {rx_tdata, len_lo};
    assign rem_hdr   = len_full - 16'd4;
    assign word_full = {rx_tdata, word[31:8]};
    assign rx_fire   = rx_tvalid && rx_tready;
    assign busy_o    = (state != S_HDR) || tx_tvalid;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= S_HDR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        rx_tready    = 1'b0;
        tx_load      = 1'b0;
        tx_load_data = 8'h00;
        case (state)
            S_HDR: begin
                rx_tready = 1'b1;
                if (rx_tvalid && hdr_cnt == 2'd3) begin
                    if (len_full < 16'd4) begin
                        state_n = S_ERR;
                    end else if (opcode == OP_ECHO) begin
                        state_n = (rem_hdr == 16'd0) ? S_HDR : S_ECHO;
                    end else if (opcode == OP_ADD || opcode == OP_XOR) begin
                        if (rem_hdr == 16'd0)           state_n = S_ERR;
                        else if (rem_hdr[1:0] != 2'b00) state_n = S_DRAIN;
                        else                            state_n = S_OPND;
                    end else begin
                        state_n = (rem_hdr == 16'd0) ? S_ERR : S_DRAIN;
                    end
                end
            end
            S_ECHO: begin
                // Stall RX whenever the echoed byte would have nowhere to go.
                rx_tready = tx_free;
                if (rx_tvalid && tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_data = rx_tdata[7:0];
                    if (rem == 16'd1) state_n = S_HDR;
                end
            end
            S_OPND: begin
                rx_tready = 1'b1;
                if (rx_tvalid && rem == 16'd1) state_n = S_RESP;
            end
            S_RESP: begin
                if (!out_cnt[2] && tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_data = acc[{out_cnt[1:0], 3'b000} +: 8];
                end
                if (out_cnt == 3'd4 && tx_tvalid && tx_tready) state_n = S_HDR;
            end
            S_DRAIN: begin
                rx_tready = 1'b1;
                if (rx_tvalid && rem == 16'd1) state_n = S_ERR;
            end
            S_ERR: begin
                if (out_cnt == 3'd0 && tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_data = ERR_BYTE;
                end
                if (out_cnt == 3'd1 && tx_tvalid && tx_tready) state_n = S_HDR;
            end
            default: state_n = S_HDR;
        endcase
        if (!reset_i) rx_tready = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            hdr_cnt   <= 2'd0;
            opcode    <= 8'h00;
            len_lo    <= 8'h00;
            rem       <= 16'd0;
            acc       <= 32'd0;
            word      <= 32'd0;
            wcnt      <= 2'd0;
            out_cnt   <= 3'd0;
            tx_tdata  <= '0;
            tx_tvalid <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= (state == S_ERR) && tx_load;

            if (tx_load) begin
                tx_tdata  <= tx_load_data;
                tx_tvalid <= 1'b1;
            end else if (tx_tready) begin
                tx_tvalid <= 1'b0;
            end

            if (rx_fire) begin
                case (state)
                    S_HDR: begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        case (hdr_cnt)
                            2'd0: opcode <= rx_tdata[7:0];
                            2'd2: len_lo <= rx_tdata[7:0];
                            2'd3: begin
                                rem  <= rem_hdr;
                                acc  <= 32'd0;
                                wcnt <= 2'd0;
                            end
                            default: ;
                        endcase
                    end
                    S_OPND: begin
                        word <= word_full;
                        wcnt <= wcnt + 2'd1;
                        rem  <= rem - 16'd1;
                        if (wcnt == 2'd3) begin
                            acc <= (opcode == OP_XOR) ? (acc ^ word_full) : (acc + word_full);
                        end
                    end
                    S_ECHO, S_DRAIN: rem <= rem - 16'd1;
                    default: ;
                endcase
            end

            // out_cnt counts response bytes loaded; it is only live in RESP/ERR.
            if (tx_load && (state == S_RESP || state == S_ERR)) begin
                out_cnt <= out_cnt + 3'd1;
            end else if (state_n == S_HDR) begin
                out_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
`timescale 1ns/1ps
// Bench for uart_alu_ctrl: directed packet table, reset sequences, and random
// packets scored against a packet-level reference model.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int tx_mode = 0;
    int gap_max = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];

    typedef struct packed {
        logic [95:0] pkt;
        int          plen;
        logic [31:0] rsp;
        int          rlen;
        int          nerr;
        int          mode;
    } vec_t;

    vec_t vecs[12];

    uart_alu_ctrl #(.DATA_WIDTH(8)) dut (
        .clk_i     (clk),
        .reset_i   (rst_n),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // TX sink: drives tx_tready at negedge, scores bytes and hold stability at negedge+1.
    initial begin
        bit         stall_q;
        logic [7:0] stall_data;
        bit         tog;
        stall_q = 1'b0;
        stall_data = 8'h00;
        tog = 1'b0;
        tx_tready = 1'b1;
        forever begin
            @(negedge clk);
            case (tx_mode)
                0: tx_tready = 1'b1;
                1: begin tog = !tog; tx_tready = tog; end
                2: tx_tready = 1'($urandom_range(0, 1));
                default: tx_tready = 1'b0;
            endcase
            #1;
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("tx_hold_valid", {31'd0, tx_tvalid}, 32'd1);
                    check("tx_hold_data", {24'd0, tx_tdata}, {24'd0, stall_data});
                end
                if (err) err_seen++;
                if (tx_tvalid && tx_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got %0h expected no byte at %0t", tx_tdata, $time);
                    end else begin
                        check("tx_byte", {24'd0, tx_tdata}, {24'd0, exp_q.pop_front()});
                    end
                end
                stall_q = tx_tvalid && !tx_tready;
                stall_data = tx_tdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        rx_tdata = b;
        rx_tvalid = 1'b1;
        #1;
        while (!rx_tready && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: byte %0h not accepted, got ready=0 expected 1", b);
        end
        @(negedge clk);
        rx_tvalid = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        #2;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({name, "_idle"}, {31'd0, (n < 3000)}, 32'd1);
        exp_q.delete();
        @(negedge clk);
    endtask

    // Reference model: expected response bytes and error count for a whole packet.
    function automatic int model_push();
        int          len;
        int          n;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] x;
        op  = pkt_q[0];
        len = {16'd0, pkt_q[3], pkt_q[2]};
        n   = len - 4;
        if (len < 4) begin
            exp_q.push_back(8'hEE);
            return 1;
        end
        if (op == 8'hEC) begin
            for (int i = 0; i < n; i++) exp_q.push_back(pkt_q[4 + i]);
            return 0;
        end
        if ((op == 8'hA0 || op == 8'hA1) && n > 0 && (n % 4) == 0) begin
            a = 32'd0;
            for (int w = 0; w < n / 4; w++) begin
                x = {pkt_q[4 + 4*w + 3], pkt_q[4 + 4*w + 2], pkt_q[4 + 4*w + 1], pkt_q[4 + 4*w]};
                a = (op == 8'hA0) ? a + x : a ^ x;
            end
            for (int k = 0; k < 4; k++) exp_q.push_back(a[8*k +: 8]);
            return 0;
        end
        exp_q.push_back(8'hEE);
        return 1;
    endfunction

    task automatic load_test1();
        logic [95:0] p;
        p = 96'hA0000C00_01000000_02000000;
        pkt_q.delete();
        for (int i = 0; i < 12; i++) pkt_q.push_back(p[95 - 8*i -: 8]);
    endtask

    initial begin
        int nerr;
        int len;
        int n;
        logic [7:0] op;
        logic [95:0] p;
        logic [31:0] r;

        vecs[0]  = '{96'hA0000C00_01000000_02000000, 12, 32'h03000000, 4, 0, 0};
        vecs[1]  = '{96'hA0000C00_FFFFFFFF_02000000, 12, 32'h01000000, 4, 0, 2};
        vecs[2]  = '{96'hA1000C00_0F0F0F0F_FF00FF00, 12, 32'hF00FF00F, 4, 0, 0};
        vecs[3]  = '{96'hEC000700_41424300_00000000,  7, 32'h41424300, 3, 0, 1};
        vecs[4]  = '{96'hEC000400_00000000_00000000,  4, 32'h00000000, 0, 0, 1};
        vecs[5]  = '{96'h55000600_11220000_00000000,  6, 32'hEE000000, 1, 1, 0};
        vecs[6]  = '{96'hA0000600_11220000_00000000,  6, 32'hEE000000, 1, 1, 1};
        vecs[7]  = '{96'hA0000200_00000000_00000000,  4, 32'hEE000000, 1, 1, 0};
        vecs[8]  = '{96'hA1000400_00000000_00000000,  4, 32'hEE000000, 1, 1, 2};
        vecs[9]  = '{96'h33000400_00000000_00000000,  4, 32'hEE000000, 1, 1, 0};
        vecs[10] = '{96'hA0000800_78563412_00000000,  8, 32'h78563412, 4, 0, 2};
        vecs[11] = '{96'hEC000300_00000000_00000000,  4, 32'hEE000000, 1, 1, 1};

        rst_n = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata = 8'h00;
        repeat (3) @(negedge clk);
        #2;
        check("reset_rx_tready", {31'd0, rx_tready}, 32'd0);
        check("reset_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("reset_tx_tdata", {24'd0, tx_tdata}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("release_rx_tready", {31'd0, rx_tready}, 32'd1);
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 12; v++) begin
            tx_mode = vecs[v].mode;
            p = vecs[v].pkt;
            r = vecs[v].rsp;
            pkt_q.delete();
            for (int i = 0; i < vecs[v].plen; i++) pkt_q.push_back(p[95 - 8*i -: 8]);
            for (int i = 0; i < vecs[v].rlen; i++) exp_q.push_back(r[31 - 8*i -: 8]);
            err_seen = 0;
            send_pkt();
            wait_idle("vec");
            check("vec_err_pulses", err_seen, vecs[v].nerr);
        end

        // Reset after 6 bytes of an ADD packet drops it.
        tx_mode = 0;
        load_test1();
        pkt_q = pkt_q[0:5];
        send_pkt();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midpkt_reset_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("midpkt_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_test1();
        exp_q = '{8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("after_reset");

        // Reset while a response byte is stalled on TX drops it.
        tx_mode = 3;
        load_test1();
        send_pkt();
        n = 0;
        #2;
        while (!tx_tvalid && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("stalled_resp_valid", {31'd0, tx_tvalid}, 32'd1);
        check("stalled_resp_byte0", {24'd0, tx_tdata}, 32'h03);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("pending_reset_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("pending_reset_tx_tdata", {24'd0, tx_tdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_mode = 1;
        @(negedge clk);
        load_test1();
        exp_q = '{8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("after_pending_reset");

        // Random packets against the reference model.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 8'hEC;
                3, 4, 5: op = 8'hA0;
                6, 7, 8: op = 8'hA1;
                default: op = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 7))
                0: len = $urandom_range(0, 11);
                1: len = (op == 8'hEC) ? $urandom_range(256, 290) : $urandom_range(4, 30);
                default: len = 4 + 4 * $urandom_range(0, 6);
            endcase
            n = (len >= 4) ? len - 4 : 0;
            pkt_q.delete();
            pkt_q.push_back(op);
            pkt_q.push_back(8'($urandom_range(0, 255)));
            pkt_q.push_back(len[7:0]);
            pkt_q.push_back(len[15:8]);
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            tx_mode = $urandom_range(0, 2);
            gap_max = $urandom_range(0, 2);
            nerr = model_push();
            err_seen = 0;
            send_pkt();
            wait_idle("rand");
            check("rand_err_pulses", err_seen, nerr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
